fpadd_arbiter: RTL and testbench
================================

Name: fpadd_arbiter

Overview:
- Round-robin arbiter that shares one pipelined single-precision FP adder (fixed latency, no stall, no valid) between N requesters.
- Registers the granted operands into the adder and carries a tag pipeline alongside it, so each result returns to the requester that issued it.
- Provides a drain/halt sequence so software can quiesce the adder.
- Sits between the requester blocks and the fpadd instance.

Parameters:
- N, 4, number of requesters (2..8).
- LAT, 5, adder latency in cycles from operand inputs to out.
- IDW, 2, requester id width, equal to clog2(N).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester operation pending
- req_ready  out  N  one-hot grant; transfer when valid&ready
- req_a  in  N*32  operand A, requester i at [32i+31:32i]
- req_b  in  N*32  operand B, same packing
- req_op  in  N  1 = subtract (optional feature only)
- drain  in  1  stop granting and empty the pipeline
- fpa_a  out  32  registered operand A to the adder
- fpa_b  out  32  registered operand B to the adder
- fpa_out  in  32  adder result
- rsp_valid  out  1  result valid this cycle
- rsp_id  out  IDW  requester the result belongs to
- rsp_data  out  32  result, equal to fpa_out when rsp_valid
- idle  out  1  halted with nothing in flight

Behaviour:
Reset:
- rst sampled on the clk edge only.
- All of the following are zero at reset: state=RUN, rr_ptr, fpa_a, fpa_b, tag pipeline valids and ids, inflight, rsp_valid, rsp_id, idle.
- rst mid-operation discards every in-flight tag; the adder's garbage outputs are never reported.

FSM (state register):
- RUN: grants allowed. Go to DRAIN when drain=1.
- DRAIN: req_ready=0. Go to HALT when inflight==0 (may be the same cycle drain rises if nothing is in flight; still passes through DRAIN for one cycle).
- HALT: req_ready=0, idle=1. Go to RUN when drain=0.
- drain falling while in DRAIN: return to RUN.

Arbitration:
- Combinational in RUN. Grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo N.
- req_ready is one-hot or zero. Requesters must hold valid and data until granted.
- On a transfer, rr_ptr <= (granted+1) mod N; with no transfer, rr_ptr holds.
- One issue per cycle maximum.

Issue:
- On transfer, fpa_a <= req_a[g] and fpa_b <= req_b[g].
- Tag stage 0 <= {1, g}; otherwise stage 0 valid <= 0 and fpa_a/fpa_b hold their values.

Tag pipeline:
- LAT+1 stages total: stage 0 is the issue register, then LAT stages shifting every cycle.
- rsp_valid = last stage valid; rsp_id = last stage id; rsp_data = fpa_out (combinational).
- Latency from handshake cycle to rsp_valid cycle is exactly LAT+1 cycles (6 at default).
- Back-to-back issues give back-to-back responses in issue order.
- No response backpressure: consumers must accept rsp_valid unconditionally.

inflight counter:
- Width clog2(LAT+2). Increments on transfer, decrements on rsp_valid, unchanged when both occur in the same cycle.
- Never exceeds LAT+1.

Optional Feature:
- Macro: FPADD_ARB_SUB_EN.
- Defined: when req_op[g]=1 on transfer, fpa_b <= {~req_b[g][31], req_b[g][30:0]}, so the adder computes A−B.
- Not defined: req_op is ignored (port remains, unused) and all operations are A+B.

Decomposition:
- Package fpadd_arb_pkg holds:
  - state enum RUN/DRAIN/HALT (2 bits);
  - FP_W=32 and SIGN_BIT=31;
  - a tag struct {valid, id}.
- One natural sub-module: rr_arbiter (N-way round-robin grant from valid vector and pointer, producing one-hot grant plus encoded index), reusable elsewhere.
- Tag pipeline and FSM stay in the top module.

Test Plan:
- Single request: req_valid=0001, a=0x3F800000 (1.0), b=0x40000000 (2.0) → ready[0] same cycle; fpa_a/fpa_b updated next cycle; rsp_valid=1, rsp_id=0 exactly 6 cycles after the handshake, with data equal to the adder model's 3.0 (0x40400000).
- All four requesters holding valid continuously → grants 0,1,2,3,0,… one per cycle; responses back-to-back with ids 0,1,2,3 in order; no gaps.
- Fairness: valid=1010 with rr_ptr=0 → grants 1, 3, 1, 3; requester 1 never granted twice in a row while 3 waits.
- Drain with 3 operations in flight → req_ready=0 from that cycle; the 3 responses still arrive; idle=1 the cycle after the last rsp_valid; dropping drain resumes grants next cycle.
- Reset asserted 2 cycles after an issue → no rsp_valid ever appears for that issue; all outputs 0 the cycle after reset; state=RUN.
- With FPADD_ARB_SUB_EN: req_op=1, a=0x40400000, b=0x3F800000 → fpa_b=0xBF800000, response 0x40000000. Without the macro, the same stimulus gives fpa_b=0x3F800000.

Source files
------------

// File: rtl/fpadd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fpadd_arb_pkg
// Shared types and constants for the FP adder arbiter slice.
//   state_t  : arbiter FSM states (RUN / DRAIN / HALT)
//   FP_W     : single-precision word width
//   SIGN_BIT : IEEE-754 sign bit position
//   tag_t    : {valid, id} travelling alongside the adder pipeline
// -----------------------------------------------------------------------------
package fpadd_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;

    // Sized for the largest supported N (8 requesters).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    // Flipping the sign of B turns the adder into a subtractor.
    function automatic logic [FP_W-1:0] fp_negate(input logic [FP_W-1:0] x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fpadd_arbiter_if.sv
// -----------------------------------------------------------------------------
// fpadd_arbiter_if
// Requester-side bus of the FP adder arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [32i+31:32i]
//   req_op              : 1 = subtract (only honoured with FPADD_ARB_SUB_EN)
//   rsp_valid/id/data   : result stream, no backpressure
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fpadd_arbiter_if
    import fpadd_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*FP_W-1:0] req_a;
    logic [N*FP_W-1:0] req_b;
    logic [N-1:0]      req_op;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [FP_W-1:0]   rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/fpadd_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// N-way round-robin grant. Searches valid[] starting at ptr, wrapping modulo N,
// and grants the first set bit.
//   en    : grants allowed this cycle
//   valid : request vector
//   ptr   : highest-priority requester this cycle
//   grant : one-hot grant (zero when nothing granted)
//   idx   : encoded index of the grant
//   any   : a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           en,
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);
    logic [IDW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IDW'((int'(ptr) + k) % N);
            if (en && !any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end
endmodule

// File: rtl/fpadd_arbiter.sv
// -----------------------------------------------------------------------------
// fpadd_arbiter
// Shares one fixed-latency pipelined FP adder between N requesters. Granted
// operands are registered into the adder and a {valid,id} tag pipeline of
// LAT+1 stages follows them so each result is routed back to its issuer.
// A drain input stops granting and waits for the pipeline to empty (idle).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus            : requester handshake/operands and response stream
//   drain          : stop granting and quiesce
//   fpa_a, fpa_b   : registered adder operands
//   fpa_out        : adder result (LAT cycles after operands)
//   idle           : halted with nothing in flight
// Build option: define FPADD_ARB_SUB_EN to honour req_op (A-B); otherwise
// req_op is ignored and every operation is A+B.
// -----------------------------------------------------------------------------
module fpadd_arbiter
    import fpadd_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 5,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst,
    fpadd_arbiter_if.slave  bus,
    input  logic            drain,
    output logic [FP_W-1:0] fpa_a,
    output logic [FP_W-1:0] fpa_b,
    input  logic [FP_W-1:0] fpa_out,
    output logic            idle
);
    localparam int CNT_W = $clog2(LAT + 2);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_nxt;
    tag_t            tag_p [LAT+1];

    logic [N-1:0]    grant;
    logic [IDW-1:0]  gidx;
    logic            xfer;
    logic            arb_en;
    logic [FP_W-1:0] sel_a;
    logic [FP_W-1:0] sel_b;
    logic [FP_W-1:0] opnd_b;

    // drain gates grants combinationally so no new issue slips in on the
    // cycle it rises.
    assign arb_en = (state == RUN) && !drain;

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
        .en    (arb_en),
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (xfer)
    );

    assign bus.req_ready = grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gidx == IDW'(i)) begin
                sel_a = bus.req_a[i*FP_W +: FP_W];
                sel_b = bus.req_b[i*FP_W +: FP_W];
            end
        end
    end

`ifdef FPADD_ARB_SUB_EN
    assign opnd_b = bus.req_op[gidx] ? fp_negate(sel_b) : sel_b;
`else
    assign opnd_b = sel_b;
    logic unused_op;
    assign unused_op = ^bus.req_op;
`endif

    // Stage 0: issue register (operands + tag); stages 1..LAT shadow the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpa_a <= '0;
            fpa_b <= '0;
            for (int k = 0; k <= LAT; k++) tag_p[k] <= '0;
        end else begin
            if (xfer) begin
                fpa_a          <= sel_a;
                fpa_b          <= opnd_b;
                tag_p[0].valid <= 1'b1;
                tag_p[0].id    <= ID_MAX_W'(gidx);
            end else begin
                tag_p[0].valid <= 1'b0;
            end
            for (int k = 1; k <= LAT; k++) tag_p[k] <= tag_p[k-1];
        end
    end

    assign bus.rsp_valid = tag_p[LAT].valid;
    assign bus.rsp_id    = tag_p[LAT].id[IDW-1:0];
    assign bus.rsp_data  = fpa_out;

    logic unused_tag;
    assign unused_tag = ^tag_p[LAT].id;

    always_comb begin
        inflight_nxt = inflight;
        if (xfer && !bus.rsp_valid)
            inflight_nxt = inflight + 1'b1;
        else if (!xfer && bus.rsp_valid)
            inflight_nxt = inflight - 1'b1;
    end

    // FSM, round-robin pointer and in-flight count. HALT is entered once the
    // count will be zero after this edge, so idle rises the cycle after the
    // last response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            rr_ptr   <= '0;
            inflight <= '0;
            idle     <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            if (xfer)
                rr_ptr <= (gidx == IDW'(N-1)) ? '0 : gidx + 1'b1;
            case (state)
                RUN: begin
                    idle <= 1'b0;
                    if (drain) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain) begin
                        state <= RUN;
                    end else if (inflight_nxt == '0) begin
                        state <= HALT;
                        idle  <= 1'b1;
                    end
                end
                HALT: begin
                    if (!drain) begin
                        state <= RUN;
                        idle  <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    idle  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_arbiter.sv
module tb_fpadd_arbiter;
    import fpadd_arb_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 5;
    localparam int IDW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        drain;
    logic [31:0] fpa_a, fpa_b, fpa_out;
    logic        idle;

    fpadd_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    fpadd_arbiter #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .drain   (drain),
        .fpa_a   (fpa_a),
        .fpa_b   (fpa_b),
        .fpa_out (fpa_out),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- floating-point model (normal numbers) ----------------
    function automatic real sp2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return r2sp(real'(int'($urandom_range(0, 2000)) - 1000));
    endfunction

    // Adder model: LAT cycles from fpa_a/fpa_b to fpa_out.
    logic [31:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= fp_add(fpa_a, fpa_b);
        for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign fpa_out = add_pipe[LAT-1];

    // ---------------- requester state and reference model ----------------
    logic [N-1:0] vld;
    logic [31:0]  ra [N];
    logic [31:0]  rb [N];
    logic         rop [N];

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t expq[$];
    int   mptr;

    int checks   = 0;
    int failures = 0;

    // Grant goes to the valid requester closest at or after the pointer.
    function automatic int exp_grant(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++)
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_issue(input int g);
        exp_t        e;
        logic [31:0] bb;
        bb = rb[g];
`ifdef FPADD_ARB_SUB_EN
        if (rop[g]) bb = {~bb[31], bb[30:0]};
`endif
        e.id   = g;
        e.data = fp_add(ra[g], bb);
        e.due  = cyc + LAT + 1;
        expq.push_back(e);
        mptr   = (g + 1) % N;
        vld[g] = 1'b0;
    endtask

    task automatic new_req(input int i);
        ra[i]  = rnd_fp();
        rb[i]  = rnd_fp();
        rop[i] = 1'($urandom_range(0, 1));
        vld[i] = 1'b1;
    endtask

    task automatic drive();
        bus.req_valid = vld;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*32 +: 32] = ra[i];
            bus.req_b[i*32 +: 32] = rb[i];
            bus.req_op[i]         = rop[i];
        end
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; drain = 1'b0; vld = '0;
        drive(); tick(); tick();
        rst = 1'b0;
        expq.delete();
        mptr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; drain = 1'b0; vld = '0;
        drive(); tick(); drive();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || idle !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b id=%0d idle=%b exp 0 0 0", bus.rsp_valid, bus.rsp_id, idle);
        end
        checks++;
        if (fpa_a !== 32'd0 || fpa_b !== 32'd0 || bus.req_ready !== '0) begin
            failures++;
            $display("FAIL reset_data got a=%h b=%h rdy=%b exp 0", fpa_a, fpa_b, bus.req_ready);
        end
        rst = 1'b0;
        expq.delete();
        mptr = 0;
    endtask

    task automatic test_single();
        do_reset();
        ra[0] = 32'h3F800000; rb[0] = 32'h40000000; rop[0] = 1'b0; vld = 4'b0001;
        drive();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0001", bus.req_ready);
        end
        vld[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick(); drive();
            if (c == 1) begin
                checks++;
                if (fpa_a !== 32'h3F800000 || fpa_b !== 32'h40000000) begin
                    failures++;
                    $display("FAIL single_opnd got a=%h b=%h exp 3f800000 40000000", fpa_a, fpa_b);
                end
            end
            checks++;
            if (c < 6 && bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_early c=%0d got rsp_valid=1 exp 0", c);
            end else if (c == 6 && (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h40400000)) begin
                failures++;
                $display("FAIL single_rsp got v=%b id=%0d d=%h exp 1 0 40400000", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int g;
        do_reset();
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 26; c++) begin
            if (c == 16) vld = '0;
            drive();
            g = exp_grant(vld, mptr);
            checks++;
            if (bus.req_ready !== onehot(g)) begin
                failures++;
                $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, onehot(g));
            end
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(expq[0].id) || bus.rsp_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL b2b_rsp cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expq[0].id, expq[0].data);
                end
                void'(expq.pop_front());
            end else if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gap cyc=%0d got rsp_valid=1 exp 0", cyc);
            end
            if (g >= 0) begin
                model_issue(g);
                if (c < 15) new_req(g);
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        int seq [4] = '{1, 3, 1, 3};
        do_reset();
        new_req(1); new_req(3);
        for (int c = 0; c < 12; c++) begin
            if (c == 4) vld = '0;
            drive();
            if (c < 4) begin
                checks++;
                if (bus.req_ready !== onehot(seq[c])) begin
                    failures++;
                    $display("FAIL fair_grant c=%0d got=%b exp=%b", c, bus.req_ready, onehot(seq[c]));
                end
            end
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(expq[0].id) || bus.rsp_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL fair_rsp cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expq[0].id, expq[0].data);
                end
                void'(expq.pop_front());
            end else if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL fair_gap cyc=%0d got rsp_valid=1 exp 0", cyc);
            end
            if (c < 4) begin
                model_issue(seq[c]);
                new_req(seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_drain();
        int g;
        int last_due;
        do_reset();
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 3; c++) begin
            drive();
            g = exp_grant(vld, mptr);
            checks++;
            if (bus.req_ready !== onehot(g)) begin
                failures++;
                $display("FAIL drain_pre c=%0d got=%b exp=%b", c, bus.req_ready, onehot(g));
            end
            model_issue(g);
            new_req(g);
            tick();
        end
        drain    = 1'b1;
        last_due = expq[$].due;
        for (int c = 0; c < 12; c++) begin
            drive();
            checks++;
            if (bus.req_ready !== '0 || idle !== (cyc > last_due)) begin
                failures++;
                $display("FAIL drain_state cyc=%0d got rdy=%b idle=%b exp rdy=0 idle=%b", cyc, bus.req_ready, idle, cyc > last_due);
            end
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(expq[0].id) || bus.rsp_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL drain_rsp cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expq[0].id, expq[0].data);
                end
                void'(expq.pop_front());
            end else if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL drain_gap cyc=%0d got rsp_valid=1 exp 0", cyc);
            end
            tick();
        end
        drain = 1'b0;
        drive(); tick(); drive();
        g = exp_grant(vld, mptr);
        checks++;
        if (bus.req_ready !== onehot(g) || idle !== 1'b0) begin
            failures++;
            $display("FAIL drain_resume got rdy=%b idle=%b exp rdy=%b idle=0", bus.req_ready, idle, onehot(g));
        end
        model_issue(g);
        vld = '0;
        tick();
        for (int c = 0; c < 8; c++) begin
            drive();
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(expq[0].id) || bus.rsp_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL drain_post cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expq[0].id, expq[0].data);
                end
                void'(expq.pop_front());
            end else if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL drain_postgap cyc=%0d got rsp_valid=1 exp 0", cyc);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        new_req(0);
        drive();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_ready got=%b exp=0001", bus.req_ready);
        end
        vld = '0;
        tick(); drive(); tick();
        rst = 1'b1;
        drive(); tick(); drive();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || idle !== 1'b0 || fpa_a !== 32'd0 || fpa_b !== 32'd0) begin
            failures++;
            $display("FAIL rmid_zero got v=%b id=%0d idle=%b a=%h b=%h exp all 0", bus.rsp_valid, bus.rsp_id, idle, fpa_a, fpa_b);
        end
        rst = 1'b0;
        mptr = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                vld = '1;
                drive();
                checks++;
                if (bus.req_ready !== onehot(exp_grant(vld, mptr))) begin
                    failures++;
                    $display("FAIL rmid_run got=%b exp=%b", bus.req_ready, onehot(exp_grant(vld, mptr)));
                end
                vld = '0;
            end
            drive();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rmid_ghost c=%0d got rsp_valid=1 exp 0", c);
            end
            tick();
        end
    endtask

    task automatic test_sub();
        logic [31:0] exp_fb;
`ifdef FPADD_ARB_SUB_EN
        exp_fb = 32'hBF800000;
`else
        exp_fb = 32'h3F800000;
`endif
        do_reset();
        ra[2] = 32'h40400000; rb[2] = 32'h3F800000; rop[2] = 1'b1; vld = 4'b0100;
        drive();
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL sub_ready got=%b exp=0100", bus.req_ready);
        end
        model_issue(2);
        tick();
        for (int c = 0; c < 7; c++) begin
            drive();
            if (c == 0) begin
                checks++;
                if (fpa_b !== exp_fb) begin
                    failures++;
                    $display("FAIL sub_fpa_b got=%h exp=%h", fpa_b, exp_fb);
                end
            end
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(expq[0].id) || bus.rsp_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL sub_rsp cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expq[0].id, expq[0].data);
                end
                void'(expq.pop_front());
            end else if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL sub_gap cyc=%0d got rsp_valid=1 exp 0", cyc);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int c = 0; c < 310; c++) begin
            drive();
            g = exp_grant(vld, mptr);
            checks++;
            if (bus.req_ready !== onehot(g)) begin
                failures++;
                $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, onehot(g));
            end
            checks++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(expq[0].id) || bus.rsp_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, expq[0].id, expq[0].data);
                end
                void'(expq.pop_front());
            end else if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_gap cyc=%0d got rsp_valid=1 exp 0", cyc);
            end
            if (g >= 0) model_issue(g);
            if (c < 295)
                for (int i = 0; i < N; i++)
                    if (!vld[i] && $urandom_range(0, 1) == 1) new_req(i);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; drain = 1'b0; vld = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = 1'b0; end
        drive();
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_drain();
        test_reset_mid();
        test_sub();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
